// File: rtl/nn_pkg.sv
// Shared fixed-point definitions and helpers for the serial neural-net layers.
package nn_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_FRAC  = 8;
   localparam int ACC_MAX   = 64;

   typedef logic signed [DEF_WIDTH-1:0] fix_t;
   typedef logic signed [ACC_MAX-1:0]   wide_t;

   typedef struct packed {
      fix_t value;
      logic ovf;
   } sat_res_t;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      DONE,
      OUT
   } bwd_state_t;

   // Arithmetic right shift (truncation toward -inf) followed by a clip to the fix_t range
   function automatic sat_res_t sat_shift(input wide_t acc, input int frac);
      sat_res_t res;
      wide_t    shifted;
      wide_t    maxV;
      wide_t    minV;
      shifted = acc >>> frac;
      maxV    = (wide_t'(1) <<< (DEF_WIDTH - 1)) - wide_t'(1);
      minV    = -(wide_t'(1) <<< (DEF_WIDTH - 1));
      res.ovf = 1'b0;
      if (shifted > maxV) begin
         res.value = fix_t'(maxV);
         res.ovf   = 1'b1;
      end else if (shifted < minV) begin
         res.value = fix_t'(minV);
         res.ovf   = 1'b1;
      end else begin
         res.value = fix_t'(shifted);
      end
      return res;
   endfunction

   // Element index of W[i][j] in a row-major flat matrix whose row 0 sits at the MSB
   function automatic int w_idx(input int i, input int j, input int nin, input int nout);
      return nin * nout - 1 - (i * nin + j);
   endfunction

endpackage

// File: rtl/linear_layer_backward_mac_unit.sv
// Bank of signed accumulators fed by one shared multiplier; one entry is updated per enabled cycle.
module mac_unit #(
   parameter int WIDTH = 16,
   parameter int ACCW  = 35,
   parameter int DEPTH = 4,
   parameter int SELW  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          en,
   input  logic [SELW-1:0]               sel,
   input  logic signed [WIDTH-1:0]       a,
   input  logic signed [WIDTH-1:0]       b,
   output logic signed [DEPTH*ACCW-1:0]  accFlat
);

   logic signed [ACCW-1:0]    acc [DEPTH];
   logic signed [2*WIDTH-1:0] aExt;
   logic signed [2*WIDTH-1:0] bExt;
   logic signed [2*WIDTH-1:0] product;

   // Full-precision signed product of the two operands
   always_comb begin
      aExt    = {{WIDTH{a[WIDTH-1]}}, a};
      bExt    = {{WIDTH{b[WIDTH-1]}}, b};
      product = aExt * bExt;
   end

   // Clear the whole bank or add the product into the selected accumulator
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int k = 0; k < DEPTH; k++) begin
            acc[k] <= '0;
         end
      end else if (en) begin
         acc[sel] <= acc[sel] + {{(ACCW-2*WIDTH){product[2*WIDTH-1]}}, product};
      end
   end

   // Expose the bank flat, entry k at the low end of slot k
   always_comb begin
      accFlat = '0;
      for (int k = 0; k < DEPTH; k++) begin
         accFlat[k*ACCW +: ACCW] = acc[k];
      end
   end

endmodule

// File: rtl/linear_layer_backward.sv
// Serial backward pass of a linear layer: grad_in = W^T * grad_out through one shared MAC.
module linear_layer_backward
   import nn_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NIN   = 4,
   parameter int NOUT  = 3,
   parameter int FRAC  = DEF_FRAC,
   parameter logic signed [WIDTH*NIN*NOUT-1:0] WEIGHTS_MATRIX_FLAT = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [WIDTH*NOUT-1:0] grad_out_flat,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [WIDTH*NIN-1:0] grad_in_flat,
   output logic                        sat
);

   localparam int ACCW = 2*WIDTH + $clog2(NOUT) + 1;
   localparam int IW   = (NOUT > 1) ? $clog2(NOUT) : 1;
   localparam int JW   = (NIN > 1) ? $clog2(NIN) : 1;

   bwd_state_t                    state;
   logic signed [WIDTH*NOUT-1:0]  gradReg;
   logic [IW-1:0]                 rowIdx;
   logic [JW-1:0]                 colIdx;
   logic signed [WIDTH-1:0]       weightSel;
   logic signed [WIDTH-1:0]       gradSel;
   logic                          macClear;
   logic                          macEn;
   logic signed [NIN*ACCW-1:0]    accFlat;
   logic signed [ACCW-1:0]        accElem;
   sat_res_t                      satRes;
   logic signed [WIDTH*NIN-1:0]   nextGradIn;
   logic                          nextSat;

   // Pick W[i][j] and g[i] for the current MAC step and decide when the bank clears or accumulates
   always_comb begin
      weightSel = WEIGHTS_MATRIX_FLAT[w_idx(int'(rowIdx), int'(colIdx), NIN, NOUT)*WIDTH +: WIDTH];
      gradSel   = gradReg[(NOUT-1-int'(rowIdx))*WIDTH +: WIDTH];
      macClear  = (state == IDLE) && in_valid && in_ready;
      macEn     = (state == MAC);
   end

   mac_unit #(
      .WIDTH (WIDTH),
      .ACCW  (ACCW),
      .DEPTH (NIN),
      .SELW  (JW)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clear   (macClear),
      .en      (macEn),
      .sel     (colIdx),
      .a       (weightSel),
      .b       (gradSel),
      .accFlat (accFlat)
   );

   // Rescale every accumulator back to the operand format and flag any clipping
   always_comb begin
      nextGradIn = '0;
      nextSat    = 1'b0;
      accElem    = '0;
      satRes     = '0;
      for (int j = 0; j < NIN; j++) begin
         accElem = accFlat[j*ACCW +: ACCW];
         satRes  = sat_shift({{(ACC_MAX-ACCW){accElem[ACCW-1]}}, accElem}, FRAC);
         nextGradIn[(NIN-1-j)*WIDTH +: WIDTH] = satRes.value;
         nextSat = nextSat | satRes.ovf;
      end
   end

   // Transaction sequencer: capture, walk j inside i, publish the result, then wait for the consumer
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         grad_in_flat <= '0;
         sat          <= 1'b0;
         gradReg      <= '0;
         rowIdx       <= '0;
         colIdx       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  gradReg  <= grad_out_flat;
                  rowIdx   <= '0;
                  colIdx   <= '0;
                  in_ready <= 1'b0;
                  state    <= MAC;
               end
            end
            MAC: begin
               if (colIdx == JW'(NIN-1)) begin
                  colIdx <= '0;
                  if (rowIdx == IW'(NOUT-1)) begin
                     state <= DONE;
                  end else begin
                     rowIdx <= rowIdx + IW'(1);
                  end
               end else begin
                  colIdx <= colIdx + JW'(1);
               end
            end
            DONE: begin
               grad_in_flat <= nextGradIn;
               sat          <= nextSat;
               out_valid    <= 1'b1;
               state        <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
